// File: rtl/grid_io_pkg.sv
// Shared constants and types for the grid IO bank.
// Config bit positions, FSM state encoding, counter width helper.
package grid_io_pkg;

  localparam int CFG_OE_BIT = 0;
  localparam int CFG_IE_BIT = 1;

  localparam int NUM_IO_DEF    = 4;
  localparam int W_CFG_DEF     = 2;
  localparam int CHAIN_LEN_DEF = NUM_IO_DEF * W_CFG_DEF;
  localparam int W_CNT         = $clog2(CHAIN_LEN_DEF + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  // Counter must hold 0..chain_len+1 (saturated overlong marker).
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 2);
  endfunction

endpackage

// File: rtl/grid_io_chan.sv
// One pad channel: combinational gating of oe/ie with isolation.
// Ports: cfg[1:0] (oe, ie), io_isol_n, outpad/soc_in data in; soc_out, soc_dir, inpad out.
module grid_io_chan
  import grid_io_pkg::*;
(
  input  logic [1:0] cfg,
  input  logic       io_isol_n,
  input  logic       outpad,
  input  logic       soc_in,
  output logic       soc_out,
  output logic       soc_dir,
  output logic       inpad
);

  logic oe;
  logic ie;

  assign oe      = io_isol_n & cfg[CFG_OE_BIT];
  assign ie      = io_isol_n & cfg[CFG_IE_BIT];
  assign soc_dir = oe;
  assign soc_out = oe & outpad;
  assign inpad   = ie & soc_in;

endmodule

// File: rtl/grid_io_bank_cfg.sv
// NUM_IO-pad IO tile behind one config-chain segment with a shadow register.
// Ports: prog_clk/pReset_n, config_enable, IO_ISOL_N, ccff_head/tail, pad buses, cfg_valid/err.
module grid_io_bank_cfg
  import grid_io_pkg::*;
#(
  parameter int NUM_IO    = 4,
  parameter int W_CFG     = 2,
  parameter int CHAIN_LEN = NUM_IO * W_CFG
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              config_enable,
  input  logic              IO_ISOL_N,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [NUM_IO-1:0] gfpga_pad_sofa_plus_io_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_sofa_plus_io_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_sofa_plus_io_SOC_DIR,
  input  logic [NUM_IO-1:0] outpad,
  output logic [NUM_IO-1:0] inpad,
  output logic              cfg_valid,
  output logic              cfg_err
);

  localparam int CW = cnt_width(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_FULL = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CHAIN_LEN + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  cfg_state_e state_q;
  cfg_state_e state_d;

  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [CW-1:0]        cnt_inc;
  logic [CHAIN_LEN-1:0] sr;
  logic [CHAIN_LEN-1:0] shadow;
  logic                 load_ok;
  logic                 load_bad;

  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = config_enable ? SHIFT : IDLE;
      SHIFT:   state_d = config_enable ? SHIFT : COMMIT;
      COMMIT:  state_d = config_enable ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A bit arriving in COMMIT opens a fresh session at count 1.
  always_comb begin
    cnt_d    = cnt_q;
    load_ok  = 1'b0;
    load_bad = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (config_enable) cnt_d = CNT_ONE;
      end
      SHIFT: begin
        if (config_enable) cnt_d = cnt_inc;
      end
      COMMIT: begin
        load_ok  = (cnt_q == CNT_FULL);
        load_bad = (cnt_q != CNT_FULL);
        if (config_enable) cnt_d = CNT_ONE;
      end
      default: cnt_d = '0;
    endcase
  end

  // Shadow takes the pre-shift chain contents on commit.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sr        <= '0;
      shadow    <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (config_enable) begin
        sr <= {sr[CHAIN_LEN-2:0], ccff_head};
      end
      if (load_ok) begin
        shadow    <= sr;
        cfg_valid <= 1'b1;
        cfg_err   <= 1'b0;
      end else if (load_bad) begin
        cfg_err   <= 1'b1;
      end
    end
  end

  assign ccff_tail = sr[CHAIN_LEN-1];

  for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_chan
    grid_io_chan u_chan (
      .cfg       (shadow[gi*W_CFG +: 2]),
      .io_isol_n (IO_ISOL_N),
      .outpad    (outpad[gi]),
      .soc_in    (gfpga_pad_sofa_plus_io_SOC_IN[gi]),
      .soc_out   (gfpga_pad_sofa_plus_io_SOC_OUT[gi]),
      .soc_dir   (gfpga_pad_sofa_plus_io_SOC_DIR[gi]),
      .inpad     (inpad[gi])
    );
  end

endmodule

// File: tb/tb_grid_io_bank_cfg.sv
// Directed bench for grid_io_bank_cfg (NUM_IO=4, W_CFG=2).
// Queues hold expected tail bits and expected committed pad states.
module tb_grid_io_bank_cfg;

  logic       prog_clk;
  logic       pReset_n;
  logic       config_enable;
  logic       IO_ISOL_N;
  logic       ccff_head;
  logic       ccff_tail;
  logic [3:0] soc_in;
  logic [3:0] soc_out;
  logic [3:0] soc_dir;
  logic [3:0] outpad;
  logic [3:0] inpad;
  logic       cfg_valid;
  logic       cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic        exp_tail_q[$];
  logic [11:0] exp_pad_q[$];

  grid_io_bank_cfg #(
    .NUM_IO (4),
    .W_CFG  (2)
  ) dut (
    .prog_clk                       (prog_clk),
    .pReset_n                       (pReset_n),
    .config_enable                  (config_enable),
    .IO_ISOL_N                      (IO_ISOL_N),
    .ccff_head                      (ccff_head),
    .ccff_tail                      (ccff_tail),
    .gfpga_pad_sofa_plus_io_SOC_IN  (soc_in),
    .gfpga_pad_sofa_plus_io_SOC_OUT (soc_out),
    .gfpga_pad_sofa_plus_io_SOC_DIR (soc_dir),
    .outpad                         (outpad),
    .inpad                          (inpad),
    .cfg_valid                      (cfg_valid),
    .cfg_err                        (cfg_err)
  );

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic chk_pads(input string tag, input logic [3:0] d,
                          input logic [3:0] o, input logic [3:0] i);
    check({tag, "_dir"}, {28'd0, soc_dir}, {28'd0, d});
    check({tag, "_out"}, {28'd0, soc_out}, {28'd0, o});
    check({tag, "_inpad"}, {28'd0, inpad}, {28'd0, i});
  endtask

  task automatic pop_pads(input string tag);
    logic [11:0] e;
    if (exp_pad_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_pad_q.pop_front();
      chk_pads(tag, e[11:8], e[7:4], e[3:0]);
    end
  endtask

  // MSB of bits[n-1:0] goes first; tail is checked once 8 bits are in flight.
  task automatic shift_seq(input logic [15:0] bits, input int n,
                           input logic [3:0] hold_dir);
    for (int i = n - 1; i >= 0; i--) begin
      config_enable = 1'b1;
      ccff_head     = bits[i];
      exp_tail_q.push_back(bits[i]);
      tick();
      if (exp_tail_q.size() == 8)
        check("tail", {31'd0, ccff_tail}, {31'd0, exp_tail_q.pop_front()});
      check("dir_stable", {28'd0, soc_dir}, {28'd0, hold_dir});
    end
    config_enable = 1'b0;
    ccff_head     = 1'b0;
  endtask

  initial begin
    pReset_n      = 1'b1;
    config_enable = 1'b0;
    IO_ISOL_N     = 1'b1;
    ccff_head     = 1'b0;
    outpad        = 4'hF;
    soc_in        = 4'hF;

    #3 pReset_n = 1'b0;
    #1;
    chk_pads("reset", 4'h0, 4'h0, 4'h0);
    check("reset_valid", {31'd0, cfg_valid}, 32'd0);
    check("reset_err", {31'd0, cfg_err}, 32'd0);
    check("reset_tail", {31'd0, ccff_tail}, 32'd0);
    tick();
    tick();
    pReset_n = 1'b0;
    #2 pReset_n = 1'b1;

    // Good load: pad3=01 pad2=10 pad1=11 pad0=00
    exp_pad_q.push_back({4'b1010, 4'b1010, 4'b0110});
    shift_seq(16'h006C, 8, 4'h0);
    tick();
    check("valid_lat1", {31'd0, cfg_valid}, 32'd0);
    tick();
    check("good_valid", {31'd0, cfg_valid}, 32'd1);
    check("good_err", {31'd0, cfg_err}, 32'd0);
    pop_pads("good");

    // Short load keeps shadow and valid, flags error
    shift_seq(16'h007F, 7, 4'b1010);
    tick();
    tick();
    check("short_err", {31'd0, cfg_err}, 32'd1);
    check("short_valid", {31'd0, cfg_valid}, 32'd1);
    chk_pads("short", 4'b1010, 4'b1010, 4'b0110);

    // Correct reload: pad3=10 pad2=01 pad1=00 pad0=11
    exp_pad_q.push_back({4'b0101, 4'b0101, 4'b1001});
    shift_seq(16'h0093, 8, 4'b1010);
    tick();
    tick();
    check("reload_err", {31'd0, cfg_err}, 32'd0);
    pop_pads("reload");
    outpad = 4'hC;
    soc_in = 4'h3;
    #1;
    chk_pads("reload_mix", 4'b0101, 4'b0100, 4'b0001);

    // Isolation is combinational and reversible
    IO_ISOL_N = 1'b0;
    #1;
    chk_pads("isol", 4'h0, 4'h0, 4'h0);
    IO_ISOL_N = 1'b1;
    #1;
    chk_pads("unisol", 4'b0101, 4'b0100, 4'b0001);
    outpad = 4'hF;
    soc_in = 4'hF;

    // Isolated during shift, then back-to-back session starting in COMMIT
    IO_ISOL_N = 1'b0;
    shift_seq(16'h006C, 8, 4'h0);
    IO_ISOL_N = 1'b1;
    tick();
    check("b2b_pre", {28'd0, soc_dir}, 32'b0101);
    exp_pad_q.push_back({4'b0101, 4'b0101, 4'b1001});
    shift_seq(16'h0093, 8, 4'b1010);
    tick();
    tick();
    check("b2b_err", {31'd0, cfg_err}, 32'd0);
    pop_pads("b2b");

    // Passthrough, overlong session
    shift_seq(16'hB4C9, 16, 4'b0101);
    tick();
    tick();
    check("long_err", {31'd0, cfg_err}, 32'd1);
    check("long_valid", {31'd0, cfg_valid}, 32'd1);
    chk_pads("long", 4'b0101, 4'b0101, 4'b1001);

    // Reset after 5 bits, before the session can commit
    shift_seq(16'h0015, 5, 4'b0101);
    #2 pReset_n = 1'b0;
    #1;
    exp_tail_q.delete();
    chk_pads("rst_mid", 4'h0, 4'h0, 4'h0);
    check("rst_mid_valid", {31'd0, cfg_valid}, 32'd0);
    check("rst_mid_tail", {31'd0, ccff_tail}, 32'd0);
    tick();
    pReset_n = 1'b1;
    tick();
    tick();
    tick();
    check("rst_nocommit_valid", {31'd0, cfg_valid}, 32'd0);
    check("rst_nocommit_err", {31'd0, cfg_err}, 32'd0);
    check("rst_nocommit_dir", {28'd0, soc_dir}, 32'd0);

    exp_pad_q.push_back({4'b1010, 4'b1010, 4'b0110});
    shift_seq(16'h006C, 8, 4'h0);
    tick();
    tick();
    check("post_rst_valid", {31'd0, cfg_valid}, 32'd1);
    check("post_rst_err", {31'd0, cfg_err}, 32'd0);
    pop_pads("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
